axi_read_responder: RTL and testbench
=====================================

Name: axi_read_responder

Overview:
AXI4 read-channel responder (slave) for the core's m_axi_ar*/m_axi_r* initiator ports. It serves instruction-fetch and data-load bursts from an internal word-addressed memory, and is the simulation/FPGA memory endpoint behind the fetcher and the memory stage. It handles one outstanding burst at a time and supports FIXED, INCR and WRAP bursts. A backdoor write port preloads program images.

Parameters:
ID_WIDTH, 13, width of arid/rid
ADDR_WIDTH, 64, byte address width
DATA_WIDTH, 64, R data width; bytes per beat NB = DATA_WIDTH/8
MEM_WORDS, 4096, depth of internal memory in DATA_WIDTH words
BASE_ADDR, 64'h0, byte address mapped to word 0
RD_LATENCY, 2, idle cycles between AR handshake and first R beat (0 allowed)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
s_axi_arid  in  ID_WIDTH  request ID
s_axi_araddr  in  ADDR_WIDTH  start byte address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  log2 bytes per beat
s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_arvalid  in  1  request valid
s_axi_arready  out  1  request accept
s_axi_rid  out  ID_WIDTH  echoed ID
s_axi_rdata  out  DATA_WIDTH  beat data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_axi_rlast  out  1  final beat
s_axi_rvalid  out  1  beat valid
s_axi_rready  in  1  beat accept
bd_we  in  1  backdoor write strobe
bd_addr  in  ADDR_WIDTH  backdoor byte address (word-aligned)
bd_wdata  in  DATA_WIDTH  backdoor data
busy  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset values: arready=1, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, busy=0, state IDLE. Memory contents are not reset.
- States: IDLE -> WAIT -> BURST -> IDLE. If RD_LATENCY=0, IDLE goes directly to BURST.
- IDLE: arready=1. On arvalid&&arready at edge T, capture id, addr, len, size, burst. Load the latency counter with RD_LATENCY and the beat counter with 0.
- WAIT: arready=0. The counter decrements each cycle. At 0, load beat 0 and enter BURST. The first rvalid is visible in cycle T+1+RD_LATENCY.
- BURST: rvalid=1 and arready=0. rid, rdata, rresp and rlast are registered and held stable while rvalid&&!rready. On handshake:
  - not last beat: load the next beat in the same edge, so a full-throughput burst needs no bubbles;
  - last beat: go to IDLE, drop rvalid, and raise arready the next cycle.
- rlast=1 exactly on beat index == len.
- Word index = (beat_addr - BASE_ADDR) >> log2(NB). DECERR with rdata=0 if beat_addr < BASE_ADDR or index >= MEM_WORDS. This is evaluated per beat, so a burst may cross into DECERR mid-way.
- Unaligned start address: return the aligned word containing the address, with rresp OKAY.
- SLVERR with rdata=0 on every beat, full len+1 beats still delivered, when any of these hold:
  - arburst=11;
  - arsize > log2(NB);
  - WRAP with len not in {1,3,7,15}.
- Next beat address:
  - FIXED: unchanged.
  - INCR: addr + (1<<size). 4KB boundary crossing is not checked.
  - WRAP: with W = (len+1)<<size, next = (addr & ~(W-1)) | ((addr + (1<<size)) & (W-1)). The start address is aligned down to size first.
- Backdoor write: mem[index] <= bd_wdata at the edge if in range, otherwise ignored. It is permitted in any state. A beat already loaded keeps its old data; later beats see the new data.
- Reset mid-burst: next cycle rvalid=0, rlast=0, arready=1, IDLE. The outstanding burst is abandoned.
- arvalid while busy is not accepted (arready=0). The initiator must hold its request.

Decomposition:
- Shared package axi_pkg (alongside the control-signal struct headers), containing:
  - burst_t enum (FIXED/INCR/WRAP/RSVD);
  - resp_t constants (OKAY/EXOKAY/SLVERR/DECERR);
  - ar_req_t struct {id, addr, len, size, burst}.
- Sub-module axi_burst_addr_gen: combinational next-address from {addr, len, size, burst}. It is reused later by the write responder.

Test Plan:
- Single beat: araddr=BASE+0x10, len=0, size=3, INCR, rready=1, RD_LATENCY=2, mem[2]=0xDEADBEEF -> one beat at T+3 with rdata=0xDEADBEEF, rresp=00, rlast=1, rid echoed; arready=1 at T+4.
- 8-beat INCR from BASE, mem[i]=i, rready=1 -> rdata 0..7 on consecutive cycles, rlast only on the 8th beat, no bubbles.
- Backpressure: same burst with rready toggling 1,0,0,1 -> rdata/rlast stable while stalled, no beat lost or duplicated, 8 handshakes total.
- WRAP len=3 size=3 at BASE+0x10 -> words 2,3,0,1.
- Out-of-range INCR len=3 starting at last word -> beat0 OKAY, beats 1..3 DECERR with rdata=0. arburst=11 -> 4 SLVERR beats.
- Reset asserted during beat 2 of 8 -> rvalid=0 next cycle, arready=1. A new len=0 request then completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 definitions for the read and write responders.
//   burst_t      : AxBURST encoding (FIXED / INCR / WRAP / reserved)
//   resp_t       : xRESP encoding plus named constants
//   ar_req_t     : captured read-address request {id, addr, len, size, burst}
//   wrap_len_ok  : legal WRAP burst lengths (2, 4, 8 or 16 beats)
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam int AXI_ID_W   = 13;
  localparam int AXI_ADDR_W = 64;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    burst_t                burst;
  } ar_req_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats (len = beats - 1).
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_read_responder_if.sv
// -----------------------------------------------------------------------------
// axi_read_responder_if
// AXI4 read address (AR) and read data (R) channel bundle.
//   master modport : drives s_axi_ar* and s_axi_rready
//   slave  modport : drives s_axi_arready and s_axi_r* (except rready)
// -----------------------------------------------------------------------------
interface axi_read_responder_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);

  logic [ID_WIDTH-1:0]   s_axi_arid;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic [2:0]            s_axi_arsize;
  logic [1:0]            s_axi_arburst;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;

  logic [ID_WIDTH-1:0]   s_axi_rid;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid
  );

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational AXI4 next-beat address calculation.
//   i_addr      : current beat byte address (WRAP callers pass a size-aligned start)
//   i_len       : beats - 1
//   i_size      : log2 bytes per beat
//   i_burst     : FIXED / INCR / WRAP (reserved is treated as INCR)
//   o_next_addr : byte address of the following beat
// -----------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  burst_t                i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_wrap_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_incr;

  always_comb begin
    w_step       = ADDR_WIDTH'(1) << i_size;
    // Total bytes covered by the wrap window: (len + 1) << size.
    w_wrap_bytes = ADDR_WIDTH'({1'b0, i_len} + 9'd1) << i_size;
    w_wrap_mask  = w_wrap_bytes - ADDR_WIDTH'(1);
    w_incr       = i_addr + w_step;
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      // Keep the window base, let the offset roll over inside the window.
      BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default:     o_next_addr = w_incr;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// -----------------------------------------------------------------------------
// axi_read_responder
// AXI4 read-channel slave serving one burst at a time from an internal
// word-addressed memory, with a backdoor write port for image preload.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : AR/R channels (slave modport)
//   bd_we       : backdoor write strobe
//   bd_addr     : backdoor byte address (word-aligned)
//   bd_wdata    : backdoor write data
//   busy        : a burst is in progress
// -----------------------------------------------------------------------------
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  axi_read_responder_if.slave   bus,
  input  logic                  bd_we,
  input  logic [ADDR_WIDTH-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0] bd_wdata,
  output logic                  busy
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int NB_LOG2 = $clog2(NB);
  localparam int IDX_W   = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } state_t;

  // ---------------------------------------------------------------------------
  // Address decode helpers
  // ---------------------------------------------------------------------------
  // The extra top bit of the subtraction is the borrow: set when addr < BASE.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !diff[ADDR_WIDTH] &&
           ((diff[ADDR_WIDTH-1:0] >> NB_LOG2) < ADDR_WIDTH'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> NB_LOG2);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  state_t                r_state;
  ar_req_t               r_req;      // addr field tracks the next beat to load
  logic                  r_slverr;
  logic [7:0]            r_beat;     // index of the next beat to load
  logic [7:0]            r_lat;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  resp_t                 r_rresp;
  logic                  r_busy;

  // ---------------------------------------------------------------------------
  // Beat source selection
  // In IDLE the beat comes straight from the AR channel so a zero-latency
  // configuration can present beat 0 right after the handshake edge.
  // ---------------------------------------------------------------------------
  logic                  w_ar_hs;
  ar_req_t               w_new_req;
  logic                  w_new_slverr;
  logic [ADDR_WIDTH-1:0] w_size_mask;
  ar_req_t               w_cur_req;
  logic                  w_cur_slverr;
  logic [7:0]            w_cur_beat;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_load;

  always_comb begin
    w_ar_hs     = bus.s_axi_arvalid && r_arready;
    w_size_mask = (ADDR_WIDTH'(1) << bus.s_axi_arsize) - ADDR_WIDTH'(1);

    w_new_req.id    = AXI_ID_W'(bus.s_axi_arid);
    w_new_req.len   = bus.s_axi_arlen;
    w_new_req.size  = bus.s_axi_arsize;
    w_new_req.burst = burst_t'(bus.s_axi_arburst);
    // Only WRAP aligns the start; INCR/FIXED keep the raw address and the
    // word decode picks the containing word.
    if (w_new_req.burst == BURST_WRAP) begin
      w_new_req.addr = AXI_ADDR_W'(bus.s_axi_araddr & ~w_size_mask);
    end else begin
      w_new_req.addr = AXI_ADDR_W'(bus.s_axi_araddr);
    end

    w_new_slverr = (w_new_req.burst == BURST_RSVD) ||
                   (int'(bus.s_axi_arsize) > NB_LOG2) ||
                   ((w_new_req.burst == BURST_WRAP) && !wrap_len_ok(bus.s_axi_arlen));

    if (r_state == ST_IDLE) begin
      w_cur_req    = w_new_req;
      w_cur_slverr = w_new_slverr;
      w_cur_beat   = 8'd0;
    end else begin
      w_cur_req    = r_req;
      w_cur_slverr = r_slverr;
      w_cur_beat   = r_beat;
    end
    w_cur_addr = ADDR_WIDTH'(w_cur_req.addr);

    w_load = ((r_state == ST_IDLE) && w_ar_hs && (RD_LATENCY == 0)) ||
             ((r_state == ST_WAIT) && (r_lat == 8'd1)) ||
             ((r_state == ST_BURST) && bus.s_axi_rready && !r_rlast);
  end

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr      (w_cur_addr),
    .i_len       (w_cur_req.len),
    .i_size      (w_cur_req.size),
    .i_burst     (w_cur_req.burst),
    .o_next_addr (w_next_addr)
  );

  // ---------------------------------------------------------------------------
  // Control FSM and registered R channel
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_slverr  <= 1'b0;
      r_beat    <= 8'd0;
      r_lat     <= 8'd0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ar_hs) begin
            r_req     <= w_new_req;
            r_slverr  <= w_new_slverr;
            r_lat     <= 8'(RD_LATENCY);
            r_beat    <= 8'd0;
            r_arready <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= (RD_LATENCY == 0) ? ST_BURST : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_lat <= r_lat - 8'd1;
          if (r_lat == 8'd1) begin
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (bus.s_axi_rready && r_rlast) begin
            r_state   <= ST_IDLE;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Beat load overrides the IDLE capture of addr/beat (later assignment wins).
      if (w_load) begin
        r_req.addr <= AXI_ADDR_W'(w_next_addr);
        r_beat     <= w_cur_beat + 8'd1;
        r_rvalid   <= 1'b1;
        r_rid      <= ID_WIDTH'(w_cur_req.id);
        r_rlast    <= (w_cur_beat == w_cur_req.len);
        if (w_cur_slverr) begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end else if (!addr_in_range(w_cur_addr)) begin
          r_rdata <= '0;
          r_rresp <= RESP_DECERR;
        end else begin
          r_rdata <= r_mem[addr_index(w_cur_addr)];
          r_rresp <= RESP_OKAY;
        end
      end
    end
  end

  // Backdoor preload; contents survive reset. A beat loaded on the same edge
  // reads the old word.
  always_ff @(posedge clk) begin
    if (bd_we && addr_in_range(bd_addr)) begin
      r_mem[addr_index(bd_addr)] <= bd_wdata;
    end
  end

  assign bus.s_axi_arready = r_arready;
  assign bus.s_axi_rvalid  = r_rvalid;
  assign bus.s_axi_rlast   = r_rlast;
  assign bus.s_axi_rid     = r_rid;
  assign bus.s_axi_rdata   = r_rdata;
  assign bus.s_axi_rresp   = r_rresp;
  assign busy              = r_busy;

endmodule

// File: tb/tb_axi_read_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_read_responder
// Directed and randomized read bursts against axi_read_responder, with the
// expected beat stream derived from AXI address arithmetic over a shadow memory.
// -----------------------------------------------------------------------------
module tb_axi_read_responder;
  import axi_pkg::*;

  localparam int          MEMW = 256;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int          LAT  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bd_we = 1'b0;
  logic [63:0] bd_addr = '0;
  logic [63:0] bd_wdata = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] ref_mem [MEMW];

  axi_read_responder_if #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) axi ();

  axi_read_responder #(
    .ID_WIDTH   (13),
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64),
    .MEM_WORDS  (MEMW),
    .BASE_ADDR  (BASE),
    .RD_LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (axi),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected data/response for beat i of a burst, from the AXI address rules.
  function automatic void model_beat(input logic [63:0] start, input int len, input int size,
                                     input int burst, input int i,
                                     output logic [63:0] data, output logic [1:0] resp);
    logic [63:0] sz, al, w, lo, a;
    if (burst == 3 || size > 3 ||
        (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))) begin
      data = '0;
      resp = 2'b10;
      return;
    end
    sz = 64'd1 << size;
    if (burst == 0) begin
      a = start;
    end else if (burst == 1) begin
      a = start + 64'(i) * sz;
    end else begin
      al = start & ~(sz - 64'd1);
      w  = 64'(len + 1) * sz;
      lo = al & ~(w - 64'd1);
      a  = lo + ((al - lo + 64'(i) * sz) % w);
    end
    if (a < BASE || (a - BASE) / 8 >= 64'(MEMW)) begin
      data = '0;
      resp = 2'b11;
    end else begin
      data = ref_mem[int'((a - BASE) / 8)];
      resp = 2'b00;
    end
  endfunction

  task automatic bd_write(input logic [63:0] addr, input logic [63:0] data);
    bd_we    = 1'b1;
    bd_addr  = addr;
    bd_wdata = data;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    if (addr >= BASE && (addr - BASE) / 8 < 64'(MEMW)) ref_mem[int'((addr - BASE) / 8)] = data;
  endtask

  // mode: 0 rready always 1, 1 pattern 1,0,0,1, 2 random. abort_at >= 0 returns
  // with that beat presented and not accepted.
  task automatic run_burst(input string name, input logic [12:0] id, input logic [63:0] addr,
                           input int len, input int size, input int burst,
                           input int mode, input int abort_at);
    int          k, n, first_k, last_k, wait_ar;
    logic        rr, stalled, h_last;
    logic [63:0] ed, h_data;
    logic [1:0]  er, h_resp;
    axi.s_axi_arid    = id;
    axi.s_axi_araddr  = addr;
    axi.s_axi_arlen   = 8'(len);
    axi.s_axi_arsize  = 3'(size);
    axi.s_axi_arburst = 2'(burst);
    axi.s_axi_arvalid = 1'b1;
    wait_ar = 0;
    while (axi.s_axi_arready !== 1'b1 && wait_ar < 20) begin
      @(posedge clk);
      #1;
      wait_ar++;
    end
    check({name, " arready"}, 64'(axi.s_axi_arready), 64'd1);
    @(posedge clk);
    #1;
    axi.s_axi_arvalid = 1'b0;
    k = 0; n = 0; first_k = -1; last_k = 0; stalled = 1'b0;
    h_data = '0; h_last = 1'b0; h_resp = '0;
    while (n <= len && k < 300) begin
      if (abort_at >= 0 && n == abort_at && axi.s_axi_rvalid === 1'b1) begin
        axi.s_axi_rready = 1'b0;
        return;
      end
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (k % 4 == 0) || (k % 4 == 3);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      axi.s_axi_rready = rr;
      if (axi.s_axi_rvalid === 1'b1) begin
        if (first_k < 0) begin
          first_k = k;
          check({name, " latency"}, 64'(k), 64'(LAT));
        end
        check({name, " arready busy"}, 64'(axi.s_axi_arready), 64'd0);
        check({name, " busy"}, 64'(busy), 64'd1);
        if (stalled) begin
          check({name, " hold rdata"}, axi.s_axi_rdata, h_data);
          check({name, " hold rlast"}, 64'(axi.s_axi_rlast), 64'(h_last));
          check({name, " hold rresp"}, 64'(axi.s_axi_rresp), 64'(h_resp));
        end
        if (rr) begin
          model_beat(addr, len, size, burst, n, ed, er);
          check($sformatf("%s beat%0d rdata", name, n), axi.s_axi_rdata, ed);
          check($sformatf("%s beat%0d rresp", name, n), 64'(axi.s_axi_rresp), 64'(er));
          check($sformatf("%s beat%0d rlast", name, n), 64'(axi.s_axi_rlast), 64'(n == len));
          check($sformatf("%s beat%0d rid", name, n), 64'(axi.s_axi_rid), 64'(id));
          n++;
          last_k  = k;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          h_data  = axi.s_axi_rdata;
          h_last  = axi.s_axi_rlast;
          h_resp  = axi.s_axi_rresp;
        end
      end
      @(posedge clk);
      #1;
      k++;
    end
    axi.s_axi_rready = 1'b0;
    check({name, " beats"}, 64'(n), 64'(len + 1));
    if (mode == 0) check({name, " no bubbles"}, 64'(last_k - first_k), 64'(len));
    check({name, " rvalid after"}, 64'(axi.s_axi_rvalid), 64'd0);
    check({name, " arready after"}, 64'(axi.s_axi_arready), 64'd1);
    check({name, " busy after"}, 64'(busy), 64'd0);
    $display("burst %s id=%0h addr=%0h len=%0d size=%0d burst=%0d beats=%0d", name, id, addr,
             len, size, burst, n);
  endtask

  initial begin
    int          b, l, s, region;
    logic [63:0] a;
    axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready  = 1'b0;
    axi.s_axi_arid    = '0;
    axi.s_axi_araddr  = '0;
    axi.s_axi_arlen   = '0;
    axi.s_axi_arsize  = '0;
    axi.s_axi_arburst = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset arready", 64'(axi.s_axi_arready), 64'd1);
    check("reset rvalid", 64'(axi.s_axi_rvalid), 64'd0);
    check("reset rlast", 64'(axi.s_axi_rlast), 64'd0);
    check("reset rid", 64'(axi.s_axi_rid), 64'd0);
    check("reset rdata", axi.s_axi_rdata, 64'd0);
    check("reset rresp", 64'(axi.s_axi_rresp), 64'd0);
    check("reset busy", 64'(busy), 64'd0);

    for (int i = 0; i < MEMW; i++) bd_write(BASE + 64'(i) * 8, {$urandom, $urandom});

    bd_write(BASE + 64'h10, 64'hDEAD_BEEF);
    run_burst("single", 13'h1ABC, BASE + 64'h10, 0, 3, 1, 0, -1);

    for (int i = 0; i < 8; i++) bd_write(BASE + 64'(i) * 8, 64'(i));
    run_burst("incr8", 13'h0005, BASE, 7, 3, 1, 0, -1);
    run_burst("backpressure", 13'h0006, BASE, 7, 3, 1, 1, -1);
    run_burst("wrap4", 13'h0007, BASE + 64'h10, 3, 3, 2, 0, -1);

    // Out-of-range backdoor writes must not alias onto words 0 or MEMW-1.
    bd_write(BASE - 64'd8, 64'hBAD1);
    bd_write(BASE + 64'(MEMW) * 8, 64'hBAD2);
    run_burst("edge", 13'h0010, BASE + 64'(MEMW - 1) * 8, 3, 3, 1, 0, -1);
    run_burst("word0", 13'h0011, BASE, 0, 3, 1, 0, -1);
    run_burst("rsvd", 13'h0012, BASE, 3, 3, 3, 0, -1);
    run_burst("unaligned", 13'h0013, BASE + 64'h13, 1, 3, 1, 0, -1);
    run_burst("fixed", 13'h0014, BASE + 64'h20, 2, 3, 0, 1, -1);
    run_burst("below", 13'h0015, BASE - 64'd16, 3, 3, 1, 0, -1);
    run_burst("badwrap", 13'h0016, BASE, 2, 3, 2, 0, -1);

    // Reset while beat 2 of 8 is presented.
    run_burst("rst_mid", 13'h0020, BASE, 7, 3, 1, 0, 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid rvalid", 64'(axi.s_axi_rvalid), 64'd0);
    check("rst_mid rlast", 64'(axi.s_axi_rlast), 64'd0);
    check("rst_mid arready", 64'(axi.s_axi_arready), 64'd1);
    check("rst_mid busy", 64'(busy), 64'd0);
    run_burst("after_rst", 13'h0021, BASE + 64'h18, 0, 3, 1, 0, -1);

    for (int t = 0; t < 24; t++) begin
      b = int'($urandom_range(0, 9));
      b = (b < 3) ? 0 : (b < 6) ? 1 : (b < 9) ? 2 : 3;
      if (b == 2 && $urandom_range(0, 4) != 0) begin
        l = (1 << $urandom_range(1, 4)) - 1;
      end else begin
        l = int'($urandom_range(0, 15));
      end
      s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      region = int'($urandom_range(0, 3));
      if (region == 0) a = BASE - 64'($urandom_range(1, 32));
      else if (region == 1) a = BASE + 64'(MEMW) * 8 - 64'($urandom_range(1, 64));
      else a = BASE + 64'($urandom_range(0, MEMW * 8 - 1));
      run_burst($sformatf("rand%0d", t), 13'($urandom), a, l, s, b, 2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
